// File: rtl/pe_relu_pool_pkg.sv
// pe_relu_pool_pkg: shared status/state enums, widths and the saturating add used by the PE output stage
//   CNN_XLEN      default signed datapath width
//   WIN_W         width of the pooling-window result counter
//   PE_STATE      status codes coming from the accumulation stage
//   PE_POOL_STATE control states of the ReLU/pool stage
//   sat_add       a+b clamped to a signed w-bit range (w <= 31)
package pe_relu_pool_pkg;
    localparam int CNN_XLEN = 16;
    localparam int WIN_W = 8;
    typedef enum logic [2:0] {INVALID, VALID, CNN_FIN, POOL_FIN, COMPL} PE_STATE;
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} PE_POOL_STATE;
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int w);
        logic signed [31:0] s, hi, lo;
        s = a + b;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        return s > hi ? hi : (s < lo ? lo : s);
    endfunction
endpackage

// File: rtl/pe_relu_pool_if.sv
// pe_relu_pool_if: bundle between accumulation/writer side (master) and the ReLU/pool stage (slave)
//   status/data/bias   accumulation status, running sum and bias into the stage
//   pool_ready         writer accepts pool_out
//   pool_out/valid     FIFO head and non-empty flag
//   done/overflow/proto_err  completion pulse and sticky error flags
interface pe_relu_pool_if import pe_relu_pool_pkg::*; #(parameter int DATA_WID = CNN_XLEN);
    PE_STATE status;
    logic signed [DATA_WID-1:0] data;
    logic signed [DATA_WID-1:0] bias;
    logic pool_ready;
    logic signed [DATA_WID-1:0] pool_out;
    logic pool_valid;
    logic done;
    logic overflow;
    logic proto_err;
    modport master (output status, data, bias, pool_ready, input pool_out, pool_valid, done, overflow, proto_err);
    modport slave (input status, data, bias, pool_ready, output pool_out, pool_valid, done, overflow, proto_err);
endinterface

// File: rtl/pe_out_fifo.sv
// pe_out_fifo: small register FIFO holding pooled results for the feature-map writer
//   clk/reset  clock and synchronous active-high reset
//   push_i/data_i  enqueue request and data (accepted when not full, or when popping)
//   pop_i      dequeue request (ignored when empty)
//   data_o     head entry; full_o/empty_o/count_o occupancy
module pe_out_fifo #(
    parameter int DATA_WID = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic [DATA_WID-1:0] data_i,
    input  logic pop_i,
    output logic [DATA_WID-1:0] data_o,
    output logic full_o,
    output logic empty_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_WID-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q, count_d;
    logic wr, rd;
    assign empty_o = count_q == '0;
    assign full_o = count_q == (AW+1)'(FIFO_DEPTH);
    assign count_o = count_q;
    assign data_o = mem_q[rd_ptr_q];
    always_comb begin
        rd = pop_i && !empty_o;
        // a pop frees the slot this cycle, so a push into a full FIFO still lands
        wr = push_i && (!full_o || rd);
        count_d = count_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_q + AW'(wr);
            rd_ptr_q <= rd_ptr_q + AW'(rd);
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/pe_relu_pool.sv
// pe_relu_pool: bias add, saturation, ReLU and max-pool of PE results, buffered toward the feature-map writer
//   clk/reset  clock and synchronous active-high reset
//   bus        pe_relu_pool_if slave: status/data/bias/pool_ready in, pool_out/pool_valid/done/overflow/proto_err out
module pe_relu_pool import pe_relu_pool_pkg::*; #(
    parameter int DATA_WID = CNN_XLEN,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic reset,
    pe_relu_pool_if.slave bus
);
    PE_POOL_STATE state_q, state_d;
    logic signed [DATA_WID-1:0] last_sum_q, pool_max_q, conv, relu, fifo_out;
    logic [WIN_W-1:0] win_cnt_q;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic overflow_q, proto_err_q, push, pop, full, empty, busy;
    pe_out_fifo #(.DATA_WID(DATA_WID), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push_i(push),
        .data_i(pool_max_q),
        .pop_i(pop),
        .data_o(fifo_out),
        .full_o(full),
        .empty_o(empty),
        .count_o(count)
    );
    always_comb begin
        busy = state_q != DRAIN;
        conv = DATA_WID'(sat_add(32'(last_sum_q), 32'(bus.bias), DATA_WID));
        relu = conv < 0 ? '0 : conv;
        pop = !empty && bus.pool_ready;
        push = busy && bus.status == POOL_FIN && win_cnt_q != '0;
        // COMPL from IDLE or ACTIVE heads to DRAIN; DRAIN leaves only once the FIFO is empty
        state_d = state_q == DRAIN ? (count == '0 ? IDLE : DRAIN)
                : bus.status == COMPL ? DRAIN
                : (state_q == IDLE && (bus.status == VALID || bus.status == CNN_FIN)) ? ACTIVE
                : state_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_sum_q <= '0;
            pool_max_q <= '0;
            win_cnt_q <= '0;
            overflow_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            overflow_q <= overflow_q | (push && full && !pop);
            proto_err_q <= proto_err_q | (!busy && bus.status != INVALID);
            if (busy && bus.status == VALID) last_sum_q <= bus.data;
            if (busy && bus.status == CNN_FIN) begin
                pool_max_q <= relu > pool_max_q ? relu : pool_max_q;
                win_cnt_q <= &win_cnt_q ? win_cnt_q : win_cnt_q + 1'b1;
                last_sum_q <= '0;
            end
            if (busy && bus.status == POOL_FIN) begin
                pool_max_q <= '0;
                win_cnt_q <= '0;
            end
        end
    end
    assign bus.pool_out = fifo_out;
    assign bus.pool_valid = !empty;
    assign bus.done = state_q == DRAIN && count == '0;
    assign bus.overflow = overflow_q;
    assign bus.proto_err = proto_err_q;
endmodule
